// File: rtl/bus_pkg.sv
// Shared types and width helpers for the bus arbiter/decoder slice.
package bus_pkg;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Number of top address bits that select a slave.
    function automatic int sel_w(input int num_slaves);
        return (num_slaves > 1) ? $clog2(num_slaves) : 1;
    endfunction

    // Width of a binary master index.
    function automatic int midx_w(input int num_masters);
        return (num_masters > 1) ? $clog2(num_masters) : 1;
    endfunction

    // Width of the ACCESS wait counter, able to hold 0..timeout.
    function automatic int cnt_w(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
import bus_pkg::*;

module rr_arbiter #(
    parameter  int NUM_MASTERS = 2,
    localparam int MIDX_W      = midx_w(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MIDX_W-1:0]      ptr,
    input  logic                   enable,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [MIDX_W-1:0]      idx
);

    // Walk the masters in rotated order starting at ptr; stop at the first request.
    always_comb begin
        logic found;
        // NOTE: every output gets a default before the search so no path infers a latch.
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int off = 0; off < NUM_MASTERS; off++) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (enable && !found && req[i] &&
                    (i == (int'(ptr) + off) % NUM_MASTERS)) begin
                    found  = 1'b1;
                    gnt[i] = 1'b1;
                    idx    = MIDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_decoder.sv
// Shared-bus controller: round-robin grant, address decode, one read/write
// per grant with slave-ready handshake and a bounded wait.
import bus_pkg::*;

module bus_arbiter_decoder #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 3,
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT     = 15
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]            m_gnt,
    output logic [NUM_MASTERS-1:0]            m_done,
    output logic                              m_err,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic [ADDR_WIDTH-1:0]             s_addr,
    output logic [DATA_WIDTH-1:0]             s_wdata,
    output logic [NUM_SLAVES-1:0]             s_wen,
    output logic [NUM_SLAVES-1:0]             s_ren,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_rdata,
    input  logic [NUM_SLAVES-1:0]             s_ready
);

    localparam int SEL_W  = sel_w(NUM_SLAVES);
    localparam int MIDX_W = midx_w(NUM_MASTERS);
    localparam int CNT_W  = cnt_w(TIMEOUT);

    state_t                 state;
    logic [MIDX_W-1:0]      rr_ptr;
    logic [MIDX_W-1:0]      owner;
    logic                   we_q;
    logic [SEL_W-1:0]       sel;
    logic [CNT_W-1:0]       cnt;

    logic [NUM_MASTERS-1:0] arb_gnt;
    logic [MIDX_W-1:0]      arb_idx;
    logic                   req_we;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [DATA_WIDTH-1:0]  req_wdata;
    logic [NUM_SLAVES-1:0]  sel_onehot;
    logic                   sel_ready;
    logic [DATA_WIDTH-1:0]  sel_rdata;

    // Requests are only looked at while idle.
    rr_arbiter #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_arb (
        .req    (m_req),
        .ptr    (rr_ptr),
        .enable (state == ST_IDLE),
        .gnt    (arb_gnt),
        .idx    (arb_idx)
    );

    // Select the winning master's payload with the one-hot grant.
    always_comb begin
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (arb_gnt[i]) begin
                req_we    = m_we[i];
                req_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                req_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Decode the latched slave index; ready/data of other slaves are never seen.
    always_comb begin
        sel_onehot = '0;
        sel_ready  = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(sel) == i) begin
                sel_onehot[i] = 1'b1;
                sel_ready     = s_ready[i];
                sel_rdata     = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Sequencer and registered outputs; reset drops grant and enables at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            we_q    <= 1'b0;
            sel     <= '0;
            cnt     <= '0;
            m_gnt   <= '0;
            m_done  <= '0;
            m_err   <= 1'b0;
            m_rdata <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_wen   <= '0;
            s_ren   <= '0;
        end else begin
            m_done <= '0;
            m_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_gnt != '0) begin
                        owner   <= arb_idx;
                        we_q    <= req_we;
                        sel     <= req_addr[ADDR_WIDTH-1 -: SEL_W];
                        s_addr  <= req_addr;
                        s_wdata <= req_wdata;
                        m_gnt   <= arb_gnt;
                        state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (int'(sel) >= NUM_SLAVES) begin
                        m_done <= m_gnt;
                        m_err  <= 1'b1;
                        state  <= ST_RESP;
                    end else begin
                        cnt <= '0;
                        if (we_q) s_wen <= sel_onehot;
                        else      s_ren <= sel_onehot;
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (sel_ready) begin
                        s_wen  <= '0;
                        s_ren  <= '0;
                        if (!we_q) m_rdata <= sel_rdata;
                        m_done <= m_gnt;
                        state  <= ST_RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        s_wen   <= '0;
                        s_ren   <= '0;
                        m_rdata <= '0;
                        m_err   <= 1'b1;
                        m_done  <= m_gnt;
                        state   <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    m_gnt  <= '0;
                    rr_ptr <= (owner == MIDX_W'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_decoder.sv
// Self-checking bench for bus_arbiter_decoder with a transaction-level model.
module tb_bus_arbiter_decoder;

    localparam int NM  = 2;
    localparam int NS  = 3;
    localparam int AW  = 7;
    localparam int DW  = 8;
    localparam int TO  = 15;
    localparam int SW  = 2;
    localparam int AWF = NM * AW;
    localparam int DWF = NM * DW;

    logic           clk = 1'b0;
    logic           rst;
    logic [NM-1:0]  m_req, m_we, m_gnt, m_done;
    logic [AWF-1:0] m_addr;
    logic [DWF-1:0] m_wdata;
    logic           m_err;
    logic [DW-1:0]  m_rdata;
    logic [AW-1:0]  s_addr;
    logic [DW-1:0]  s_wdata;
    logic [NS-1:0]  s_wen, s_ren, s_ready;
    logic [NS*DW-1:0] s_rdata;

    bus_arbiter_decoder #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_gnt(m_gnt), .m_done(m_done), .m_err(m_err),
        .m_rdata(m_rdata), .s_addr(s_addr), .s_wdata(s_wdata), .s_wen(s_wen),
        .s_ren(s_ren), .s_rdata(s_rdata), .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Slave model: ready after lat[j] wait states of continuous enable.
    int   lat [NS] = '{0, 0, 0};
    logic ready_noise = 1'b0;
    int   en_cnt = 0;

    // Transaction-level reference state.
    int            model_ptr;
    logic [DW-1:0] model_rdata;

    // Observations from the last transaction.
    int            obs_edges;
    logic [NM-1:0] obs_done, obs_gnt1, obs_done_after;
    logic          obs_err, obs_timeout;
    logic [DW-1:0] obs_rdata, obs_swdata;
    logic [AW-1:0] obs_saddr;
    int            obs_en_cycles, obs_viol;
    logic [NS-1:0] obs_en_or, obs_wen_or;

    always @(negedge clk) begin
        logic [NS-1:0] en, nxt;
        en  = s_wen | s_ren;
        nxt = ready_noise ? NS'($urandom) : '0;
        if (en == '0) en_cnt = 0;
        for (int j = 0; j < NS; j++)
            if (en[j]) nxt[j] = (en_cnt == lat[j]);
        if (en != '0) en_cnt++;
        s_ready = nxt;
    end

    function automatic int exp_owner(input logic [NM-1:0] req);
        for (int o = 0; o < NM; o++)
            if (req[(model_ptr + o) % NM]) return (model_ptr + o) % NM;
        return 0;
    endfunction

    // Drive one request set from IDLE and record what the DUT does until m_done.
    task automatic run_txn(input logic [NM-1:0] req, input logic [NM-1:0] we,
                           input logic [AWF-1:0] addr, input logic [DWF-1:0] wdata,
                           input logic scramble);
        logic [NS-1:0] en;
        obs_edges = 0; obs_done = '0; obs_gnt1 = '0; obs_err = 1'b0; obs_rdata = '0;
        obs_en_cycles = 0; obs_viol = 0; obs_en_or = '0; obs_wen_or = '0;
        obs_timeout = 1'b0; obs_saddr = '0; obs_swdata = '0;
        m_req = req; m_we = we; m_addr = addr; m_wdata = wdata;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); @(negedge clk);
            en = s_wen | s_ren;
            if ($countones(m_gnt) > 1 || $countones(en) > 1 || $countones(m_done) > 1) obs_viol++;
            if (en != '0) begin
                obs_en_cycles++;
                obs_en_or  = obs_en_or | en;
                obs_wen_or = obs_wen_or | s_wen;
            end
            if (k == 1) begin
                obs_gnt1 = m_gnt; obs_saddr = s_addr; obs_swdata = s_wdata;
                if (scramble) begin
                    m_req = NM'($urandom); m_we = NM'($urandom);
                    m_addr = AWF'($urandom); m_wdata = DWF'($urandom);
                end
            end
            if (m_done != '0) begin
                obs_edges = k; obs_done = m_done; obs_err = m_err; obs_rdata = m_rdata;
                break;
            end
        end
        if (obs_edges == 0) obs_timeout = 1'b1;
        @(posedge clk); #1;
        obs_done_after = m_done;
        m_req = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; s_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (m_gnt !== '0)   begin errors++; $display("FAIL rst_gnt: got %0h expected 0", m_gnt); end
        checks++; if (m_done !== '0)  begin errors++; $display("FAIL rst_done: got %0h expected 0", m_done); end
        checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0h expected 0", m_err); end
        checks++; if ((s_wen | s_ren) !== '0) begin errors++; $display("FAIL rst_en: got %0h expected 0", s_wen | s_ren); end
        checks++; if (s_addr !== '0)  begin errors++; $display("FAIL rst_saddr: got %0h expected 0", s_addr); end
        checks++; if (s_wdata !== '0) begin errors++; $display("FAIL rst_swdata: got %0h expected 0", s_wdata); end
        checks++; if (m_rdata !== '0) begin errors++; $display("FAIL rst_rdata: got %0h expected 0", m_rdata); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_ptr = 0; model_rdata = '0;
    endtask

    task automatic test_single_write;
        lat[1] = 0;
        run_txn(2'b01, 2'b01, {7'h00, 7'b01_00101}, {8'h00, 8'hA5}, 1'b0);
        checks++; if (obs_timeout !== 1'b0) begin errors++; $display("FAIL wr_no_done: got %0h expected 0", obs_timeout); end
        checks++; if (obs_edges !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", obs_edges); end
        checks++; if (obs_done !== 2'b01) begin errors++; $display("FAIL wr_done: got %0h expected 1", obs_done); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL wr_err: got %0h expected 0", obs_err); end
        checks++; if (obs_gnt1 !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %0h expected 1", obs_gnt1); end
        checks++; if (obs_en_cycles !== 1) begin errors++; $display("FAIL wr_en_cycles: got %0d expected 1", obs_en_cycles); end
        checks++; if (obs_wen_or !== 3'b010 || obs_en_or !== 3'b010) begin errors++; $display("FAIL wr_wen: got %0h expected 2", obs_en_or); end
        checks++; if (obs_saddr !== 7'h25) begin errors++; $display("FAIL wr_saddr: got %0h expected 25", obs_saddr); end
        checks++; if (obs_swdata !== 8'hA5) begin errors++; $display("FAIL wr_swdata: got %0h expected a5", obs_swdata); end
        checks++; if (obs_rdata !== model_rdata) begin errors++; $display("FAIL wr_rdata_hold: got %0h expected %0h", obs_rdata, model_rdata); end
        checks++; if (obs_done_after !== '0) begin errors++; $display("FAIL wr_done_pulse: got %0h expected 0", obs_done_after); end
        model_ptr = 1;
    endtask

    task automatic test_read_wait;
        lat[2] = 3;
        s_rdata[2*DW +: DW] = 8'h3C;
        run_txn(2'b10, 2'b00, {7'b10_00011, 7'h00}, '0, 1'b0);
        checks++; if (obs_edges !== 6) begin errors++; $display("FAIL rd_latency: got %0d expected 6", obs_edges); end
        checks++; if (obs_en_cycles !== 4) begin errors++; $display("FAIL rd_ren_cycles: got %0d expected 4", obs_en_cycles); end
        checks++; if (obs_en_or !== 3'b100 || obs_wen_or !== 3'b000) begin errors++; $display("FAIL rd_ren: got %0h expected 4", obs_en_or); end
        checks++; if (obs_done !== 2'b10) begin errors++; $display("FAIL rd_done: got %0h expected 2", obs_done); end
        checks++; if (obs_rdata !== 8'h3C) begin errors++; $display("FAIL rd_rdata: got %0h expected 3c", obs_rdata); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL rd_err: got %0h expected 0", obs_err); end
        model_rdata = 8'h3C; model_ptr = 0;
        lat[2] = 0;
    endtask

    task automatic test_fairness;
        int count = 0, last = 0, viol = 0, exp_o;
        lat[0] = 0;
        m_req = 2'b11; m_we = 2'b11; m_addr = {7'h05, 7'h0A}; m_wdata = {8'h11, 8'h22};
        for (int cyc = 1; cyc <= 200 && count < 6; cyc++) begin
            @(posedge clk); @(negedge clk);
            if ($countones(m_gnt) > 1 || $countones(m_done) > 1) viol++;
            if (m_done != '0) begin
                exp_o = model_ptr;
                checks++; if (m_done !== NM'(1 << exp_o)) begin errors++; $display("FAIL rr_order[%0d]: got %0h expected %0h", count, m_done, 1 << exp_o); end
                checks++; if (m_gnt !== m_done) begin errors++; $display("FAIL rr_gnt_resp[%0d]: got %0h expected %0h", count, m_gnt, m_done); end
                if (count > 0) begin
                    checks++; if (cyc - last !== 4) begin errors++; $display("FAIL rr_gap[%0d]: got %0d expected 4", count, cyc - last); end
                end
                model_ptr = (exp_o + 1) % NM;
                last = cyc; count++;
            end
        end
        checks++; if (count !== 6) begin errors++; $display("FAIL rr_count: got %0d expected 6", count); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL rr_onehot: got %0d expected 0", viol); end
        @(posedge clk); #1;
        m_req = '0;
    endtask

    task automatic test_decode_error;
        run_txn(2'b01, 2'b00, {7'h00, 7'b11_00000}, '0, 1'b0);
        checks++; if (obs_edges !== 2) begin errors++; $display("FAIL dec_latency: got %0d expected 2", obs_edges); end
        checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL dec_err: got %0h expected 1", obs_err); end
        checks++; if (obs_en_or !== '0) begin errors++; $display("FAIL dec_no_enable: got %0h expected 0", obs_en_or); end
        checks++; if (obs_done !== 2'b01) begin errors++; $display("FAIL dec_done: got %0h expected 1", obs_done); end
        checks++; if (obs_rdata !== model_rdata) begin errors++; $display("FAIL dec_rdata: got %0h expected %0h", obs_rdata, model_rdata); end
        model_ptr = 1;
    endtask

    task automatic test_timeout;
        lat[0] = 99;
        run_txn(2'b10, 2'b00, {7'b00_00001, 7'h00}, '0, 1'b0);
        checks++; if (obs_edges !== 2 + TO) begin errors++; $display("FAIL to_latency: got %0d expected %0d", obs_edges, 2 + TO); end
        checks++; if (obs_en_cycles !== TO) begin errors++; $display("FAIL to_en_cycles: got %0d expected %0d", obs_en_cycles, TO); end
        checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL to_err: got %0h expected 1", obs_err); end
        checks++; if (obs_rdata !== '0) begin errors++; $display("FAIL to_rdata: got %0h expected 0", obs_rdata); end
        checks++; if (obs_done !== 2'b10) begin errors++; $display("FAIL to_done: got %0h expected 2", obs_done); end
        model_rdata = '0; model_ptr = 0; lat[0] = 0;
        lat[1] = 1;
        s_rdata[1*DW +: DW] = 8'h5A;
        run_txn(2'b01, 2'b00, {7'h00, 7'b01_00000}, '0, 1'b0);
        checks++; if (obs_edges !== 4) begin errors++; $display("FAIL to_next_latency: got %0d expected 4", obs_edges); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL to_next_err: got %0h expected 0", obs_err); end
        checks++; if (obs_rdata !== 8'h5A) begin errors++; $display("FAIL to_next_rdata: got %0h expected 5a", obs_rdata); end
        model_rdata = 8'h5A; model_ptr = 1; lat[1] = 0;
    endtask

    task automatic test_random;
        logic [NM-1:0]  req, we;
        logic [AWF-1:0] addr;
        logic [DWF-1:0] wdata;
        logic [AW-1:0]  a;
        logic [DW-1:0]  sdata [NS];
        logic [DW-1:0]  exp_rdata;
        logic [NS-1:0]  exp_en;
        int o, sel, acc;
        logic dec_err, tmo;
        ready_noise = 1'b1;
        for (int it = 0; it < 40; it++) begin
            for (int j = 0; j < NS; j++) begin
                lat[j]   = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 4));
                sdata[j] = DW'($urandom);
                s_rdata[j*DW +: DW] = sdata[j];
            end
            req   = NM'($urandom_range(1, (1 << NM) - 1));
            we    = NM'($urandom);
            addr  = AWF'($urandom);
            wdata = DWF'($urandom);
            o       = exp_owner(req);
            a       = addr[o*AW +: AW];
            sel     = int'(a[AW-1 -: SW]);
            dec_err = (sel >= NS);
            tmo     = !dec_err && (lat[dec_err ? 0 : sel] >= TO);
            acc     = dec_err ? 0 : (tmo ? TO : lat[sel] + 1);
            exp_en  = dec_err ? '0 : NS'(1 << sel);
            if (tmo) exp_rdata = '0;
            else if (!dec_err && !we[o]) exp_rdata = sdata[sel];
            else exp_rdata = model_rdata;
            run_txn(req, we, addr, wdata, 1'b1);
            checks++; if (obs_done !== NM'(1 << o)) begin errors++; $display("FAIL rnd%0d_owner: got %0h expected %0h", it, obs_done, 1 << o); end
            checks++; if (obs_gnt1 !== NM'(1 << o)) begin errors++; $display("FAIL rnd%0d_gnt: got %0h expected %0h", it, obs_gnt1, 1 << o); end
            checks++; if (obs_edges !== 2 + acc) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", it, obs_edges, 2 + acc); end
            checks++; if (obs_err !== (dec_err || tmo)) begin errors++; $display("FAIL rnd%0d_err: got %0h expected %0h", it, obs_err, dec_err || tmo); end
            checks++; if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL rnd%0d_rdata: got %0h expected %0h", it, obs_rdata, exp_rdata); end
            checks++; if (obs_en_cycles !== acc) begin errors++; $display("FAIL rnd%0d_en_cycles: got %0d expected %0d", it, obs_en_cycles, acc); end
            checks++; if (obs_en_or !== exp_en || obs_wen_or !== (we[o] ? exp_en : '0)) begin errors++; $display("FAIL rnd%0d_enable: got %0h/%0h expected %0h", it, obs_en_or, obs_wen_or, exp_en); end
            checks++; if (obs_saddr !== a) begin errors++; $display("FAIL rnd%0d_saddr: got %0h expected %0h", it, obs_saddr, a); end
            checks++; if (obs_swdata !== wdata[o*DW +: DW]) begin errors++; $display("FAIL rnd%0d_swdata: got %0h expected %0h", it, obs_swdata, wdata[o*DW +: DW]); end
            checks++; if (obs_viol !== 0 || obs_done_after !== '0) begin errors++; $display("FAIL rnd%0d_onehot_pulse: got %0d/%0h expected 0/0", it, obs_viol, obs_done_after); end
            model_rdata = exp_rdata;
            model_ptr   = (o + 1) % NM;
        end
        ready_noise = 1'b0;
        for (int j = 0; j < NS; j++) lat[j] = 0;
    endtask

    task automatic test_reset_mid_access;
        logic found = 1'b0;
        int done_seen = 0;
        run_txn(2'b01, 2'b01, {7'h00, 7'h01}, {8'h00, 8'h77}, 1'b0);
        model_ptr = 1;
        lat[2] = 99;
        m_req = 2'b10; m_we = 2'b10; m_addr = {7'b10_01010, 7'h00}; m_wdata = {8'h99, 8'h00};
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (s_wen != '0) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL rma_wen_seen: got %0h expected 1", found); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (m_gnt !== '0 || s_wen !== '0 || s_ren !== '0) begin errors++; $display("FAIL rma_drop: got gnt=%0h wen=%0h ren=%0h expected 0", m_gnt, s_wen, s_ren); end
        checks++; if (m_done !== '0 || m_err !== 1'b0) begin errors++; $display("FAIL rma_done: got %0h expected 0", m_done); end
        checks++; if (s_addr !== '0 || s_wdata !== '0 || m_rdata !== '0) begin errors++; $display("FAIL rma_data: got %0h/%0h/%0h expected 0", s_addr, s_wdata, m_rdata); end
        rst = 1'b0; m_req = '0;
        model_ptr = 0; model_rdata = '0; lat[2] = 0;
        repeat (5) begin
            @(negedge clk);
            if (m_done != '0) done_seen++;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL rma_no_done: got %0d expected 0", done_seen); end
        s_rdata[0 +: DW] = 8'hC3;
        run_txn(2'b11, 2'b00, {7'h02, 7'h03}, '0, 1'b0);
        checks++; if (obs_done !== 2'b01) begin errors++; $display("FAIL rma_ptr_zero: got %0h expected 1", obs_done); end
        checks++; if (obs_rdata !== 8'hC3) begin errors++; $display("FAIL rma_rdata: got %0h expected c3", obs_rdata); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_wait();
        test_fairness();
        test_decode_error();
        test_timeout();
        test_random();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_decoder.md
# bus_arbiter_decoder

Parametrised shared-bus controller: arbitrates between NUM_MASTERS request/grant masters with round-robin fairness, decodes the granted address to one of NUM_SLAVES slaves, and sequences a single read or write with slave-ready handshake and timeout. It replaces the fixed two-master, externally selected mux/decoder between the masters and the slave enable lines. Adds fair arbitration, per-master completion and error reporting, and a wait-state mechanism.

## Interface
Parameters:
- NUM_MASTERS, 2, number of masters (≥2)
- NUM_SLAVES, 3, number of slaves (≥2)
- ADDR_WIDTH, 7, address width; the top SEL_W=$clog2(NUM_SLAVES) bits select the slave
- DATA_WIDTH, 8, data width
- TIMEOUT, 15, maximum number of ACCESS cycles to wait for s_ready (≥1)

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- m_req  in  NUM_MASTERS  per-master request
- m_we  in  NUM_MASTERS  1 = write, 0 = read
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  flattened; master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_wdata  in  NUM_MASTERS*DATA_WIDTH  flattened write data
- m_gnt  out  NUM_MASTERS  one-hot grant
- m_done  out  NUM_MASTERS  one-cycle completion pulse to the owner
- m_err  out  1  valid with m_done; decode error or timeout
- m_rdata  out  DATA_WIDTH  read data, valid with m_done
- s_addr  out  ADDR_WIDTH  latched address of the owner
- s_wdata  out  DATA_WIDTH  latched write data
- s_wen  out  NUM_SLAVES  one-hot write enable
- s_ren  out  NUM_SLAVES  one-hot read enable
- s_rdata  in  NUM_SLAVES*DATA_WIDTH  flattened slave read data
- s_ready  in  NUM_SLAVES  slave completion strobe

## Operation
- FSM states: IDLE, ADDR, ACCESS, RESP. All outputs are registered.
- IDLE:
  - If any m_req is high, the round-robin pick starts at rr_ptr.
  - Latch owner, m_we, m_addr and m_wdata of the owner.
  - Compute slave index sel = addr[ADDR_WIDTH-1 -: SEL_W].
  - Go to ADDR.
- ADDR:
  - m_gnt[owner]=1; s_addr and s_wdata are driven.
  - If sel ≥ NUM_SLAVES, set the error flag and go to RESP with no enable asserted.
  - Otherwise go to ACCESS.
- ACCESS:
  - Assert s_wen[sel] if the access is a write, else s_ren[sel].
  - The enable stays high until s_ready[sel] is sampled high; m_rdata then captures s_rdata[sel] on a read.
  - Count the ACCESS cycles. If TIMEOUT cycles pass without ready, drop the enable, set the error flag, force m_rdata=0, and go to RESP.
- RESP:
  - m_done[owner]=1 and m_err=flag for exactly one cycle. m_gnt stays high during RESP.
  - rr_ptr = (owner+1) mod NUM_MASTERS. Go to IDLE.
- Request and payload lines are sampled only in IDLE. Changes to m_req, m_addr or m_wdata while granted are ignored.
- A master dropping m_req mid-transaction does not abort it; the transaction completes and m_done still pulses.
- s_ready from non-selected slaves is ignored. s_ready high in IDLE, ADDR or RESP is ignored.
- Writes: m_rdata holds its previous value.
- Reset:
  - Values: state=IDLE, rr_ptr=0, counter=0; m_gnt, m_done, m_err, s_wen, s_ren all 0; s_addr, s_wdata, m_rdata all 0.
  - Reset mid-transaction drops all enables and the grant on the next edge. No m_done is issued.

## Timing
- m_req[i] sampled high at edge N (state IDLE): m_gnt[i] goes high after edge N+1 (ADDR), and the enable is high after edge N+2 (ACCESS).
- If s_ready is high in that first ACCESS cycle, m_done is high after edge N+3. Minimum transaction = 4 cycles.
- Each wait state adds one cycle.
- Timeout: m_done arrives TIMEOUT cycles after ACCESS entry, plus one for RESP.
- Decode error: m_done+m_err is high after edge N+2; no slave enable is asserted at any point.
- Back-to-back: one IDLE cycle separates transactions. With every master requesting continuously, grants rotate 0,1,…,NUM_MASTERS-1,0.
- At most one bit of m_gnt, of s_wen|s_ren, and of m_done is high in any cycle.

## Structure
- Package bus_pkg holds:
  - the state enum (IDLE/ADDR/ACCESS/RESP);
  - the SEL_W and MIDX_W=$clog2(NUM_MASTERS) helper functions;
  - the timeout counter width $clog2(TIMEOUT+1).
- Sub-module rr_arbiter(NUM_MASTERS):
  - inputs: req, ptr, enable;
  - outputs: one-hot grant and binary index;
  - combinational rotate-priority-encode.
- The FSM, datapath latches and decoder live in bus_arbiter_decoder.

## Test plan
- Single write: master 0 requests write to addr 7'b01_00101, wdata 8'hA5, with s_ready[1] tied high. Expected: s_wen=3'b010 for one cycle, s_addr=7'h25, m_done[0] 4 cycles after the request, m_err=0.
- Read with wait states: master 1 reads addr 7'b10_00011; s_ready[2] asserted 3 cycles after s_ren[2] rises; s_rdata[2]=8'h3C. Expected: s_ren[2] high for exactly 4 cycles, m_rdata=8'h3C with m_done[1].
- Fairness: both masters hold m_req high for 6 transactions. Expected: grant order 0,1,0,1,0,1 and no overlapping grants.
- Decode error: address top bits 2'b11 with NUM_SLAVES=3. Expected: no enable asserted, m_done+m_err 3 cycles after the request.
- Timeout: s_ready never asserted, TIMEOUT=15. Expected: enable high 15 cycles, then m_err=1, m_rdata=0, and the next request is served normally.
- Reset mid-ACCESS: rst asserted while s_wen is high. Expected: every output 0 on the next edge, no m_done, rr_ptr=0 afterwards.
